ysyx_25030081_ifu: RTL and testbench

- Instruction fetch unit for the multicycle ysyx_25030081 core.
- Owns the architectural PC register and consumes the next-PC value produced by the core's next-PC logic.
- Issues one instruction-memory read per instruction and hands the fetched word to decode over a valid/ready handshake.
- Waits for a commit pulse carrying next_pc, then fetches the next instruction. The unit is a request/response state machine plus a retired-instruction counter.

---
 rtl/ysyx_25030081_ifu.sv | 63 ++++++
 tb/tb_ysyx_25030081_ifu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_ifu.sv
// ysyx_25030081_ifu: multicycle instruction fetch unit with request/response FSM,
// sticky fault flag and retired-instruction counter.
module ysyx_25030081_ifu #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h80000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  output logic                  imem_resp_ready,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] next_pc,
  output logic                  fetch_err,
  output logic [DATA_WIDTH-1:0] retired_cnt
);
  typedef enum logic [2:0] {REQ, RESP, HOLD, EXEC, ERR} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic resp_fire, commit_fire, aligned;
  assign resp_fire       = state == RESP && imem_resp_valid;
  assign commit_fire     = state == EXEC && commit_valid;
  assign aligned         = next_pc[1:0] == 2'b00;
  assign imem_req_valid  = state == REQ;
  assign imem_resp_ready = state == RESP;
  assign inst_valid      = state == HOLD;
  assign imem_req_addr   = pc;
  assign inst_pc         = pc;
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:     state_nxt = imem_req_ready ? RESP : REQ;
      RESP:    state_nxt = !imem_resp_valid ? RESP : imem_resp_err ? ERR : HOLD;
      HOLD:    state_nxt = inst_ready ? EXEC : HOLD;
      EXEC:    state_nxt = !commit_valid ? EXEC : aligned ? REQ : ERR;
      default: state_nxt = ERR;
    endcase
  end
  // Reset wins over any handshake that fires in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      inst        <= '0;
      retired_cnt <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (resp_fire && !imem_resp_err) inst <= imem_resp_data;
      if (commit_fire) retired_cnt <= retired_cnt + DATA_WIDTH'(1);
      if (commit_fire && aligned) pc <= next_pc;
      if ((resp_fire && imem_resp_err) || (commit_fire && !aligned)) fetch_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// tb_ysyx_25030081_ifu: randomized transaction-level bench with a reference model of pc,
// retired count, fault flag and a synthetic instruction memory.
module tb_ysyx_25030081_ifu;
  localparam logic [31:0] RST_PC = 32'h80000000;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic inst_valid, inst_ready, commit_valid, fetch_err;
  logic [31:0] req_addr, resp_data, inst, inst_pc, next_pc, retired_cnt;
  logic s_rst_n, s_req_valid, s_resp_ready, s_inst_valid, s_fetch_err, s_go;
  logic [3:0] s_addr, s_inst, s_inst_pc, s_retired;
  int errs = 0, checks = 0, req_fires = 0;
  logic [31:0] exp_pc, exp_cnt;
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && req_valid && req_ready) req_fires <= req_fires + 1;
  ysyx_25030081_ifu u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(req_valid), .imem_req_ready(req_ready),
    .imem_req_addr(req_addr), .imem_resp_valid(resp_valid), .imem_resp_ready(resp_ready),
    .imem_resp_data(resp_data), .imem_resp_err(resp_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .commit_valid(commit_valid),
    .next_pc(next_pc), .fetch_err(fetch_err), .retired_cnt(retired_cnt)
  );
  // Narrow instance so the counter wrap can be reached in a few cycles.
  ysyx_25030081_ifu #(.DATA_WIDTH(4), .RESET_PC(4'h0)) u_small (
    .clk(clk), .rst_n(s_rst_n), .imem_req_valid(s_req_valid), .imem_req_ready(s_go),
    .imem_req_addr(s_addr), .imem_resp_valid(s_go), .imem_resp_ready(s_resp_ready),
    .imem_resp_data(4'h5), .imem_resp_err(1'b0), .inst_valid(s_inst_valid),
    .inst_ready(s_go), .inst(s_inst), .inst_pc(s_inst_pc), .commit_valid(s_go),
    .next_pc(4'h4), .fetch_err(s_fetch_err), .retired_cnt(s_retired)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == RST_PC ? 32'h00000013 : {a[15:0], ~a[15:0]} ^ 32'h00001234;
  endfunction
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear_inputs();
    req_ready = 0; resp_valid = 0; resp_err = 0; resp_data = 0;
    inst_ready = 0; commit_valid = 0; next_pc = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    step();
    rst_n = 1;
    exp_pc = RST_PC;
    exp_cnt = 0;
  endtask
  task automatic do_fetch(input int req_wait, input int resp_wait, input bit rerr, input bit noise,
                          output logic [31:0] addr, output bit held);
    addr = req_addr;
    held = 1;
    for (int i = 0; i < req_wait; i++) begin
      held &= req_valid === 1'b1 && req_addr === addr && resp_ready === 1'b0;
      req_ready = 0;
      if (noise) begin
        resp_valid = 1'($urandom); resp_data = $urandom; commit_valid = 1'($urandom); next_pc = $urandom;
      end
      step();
    end
    held &= req_valid === 1'b1 && req_addr === addr;
    req_ready = 1;
    step();
    req_ready = 0; resp_valid = 0; commit_valid = 0;
    for (int i = 0; i < resp_wait; i++) begin
      held &= req_valid === 1'b0 && resp_ready === 1'b1 && inst_valid === 1'b0;
      if (noise) begin
        req_ready = 1'($urandom); commit_valid = 1'($urandom); next_pc = $urandom;
      end
      step();
    end
    held &= resp_ready === 1'b1;
    req_ready = 0; commit_valid = 0;
    resp_valid = 1; resp_data = mem_word(addr); resp_err = rerr;
    step();
    resp_valid = 0; resp_err = 0;
  endtask
  task automatic do_hold(input int wait_cycles, input bit inject, output bit held);
    logic [31:0] i0, p0, c0;
    i0 = inst; p0 = inst_pc; c0 = retired_cnt;
    held = inst_valid === 1'b1;
    for (int i = 0; i < wait_cycles; i++) begin
      inst_ready = 0; commit_valid = inject; next_pc = 32'h80000100;
      step();
      held &= inst_valid === 1'b1 && inst === i0 && inst_pc === p0 && retired_cnt === c0;
    end
    commit_valid = 0; inst_ready = 1;
    step();
    inst_ready = 0;
  endtask
  task automatic do_commit(input logic [31:0] npc, input int delay);
    for (int i = 0; i < delay; i++) step();
    commit_valid = 1; next_pc = npc;
    step();
    commit_valid = 0;
    exp_cnt = exp_cnt + 1;
    if (npc[1:0] == 2'b00) exp_pc = npc;
  endtask
  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    req_ready = 1; resp_valid = 1; commit_valid = 1; next_pc = 32'h4;
    step();
    checks++; if (req_valid !== 1'b1) begin errs++; $display("FAIL reset_req_valid got=%b want=1", req_valid); end
    checks++; if (req_addr !== RST_PC) begin errs++; $display("FAIL reset_addr got=%h want=%h", req_addr, RST_PC); end
    checks++; if (resp_ready !== 1'b0 || inst_valid !== 1'b0) begin errs++; $display("FAIL reset_handshake resp_ready=%b inst_valid=%b want=0,0", resp_ready, inst_valid); end
    checks++; if (inst !== 32'h0 || retired_cnt !== 32'h0 || fetch_err !== 1'b0) begin errs++; $display("FAIL reset_regs inst=%h cnt=%h err=%b want=0,0,0", inst, retired_cnt, fetch_err); end
    clear_inputs();
    rst_n = 1;
  endtask
  task automatic test_first_fetch();
    logic [31:0] addr; bit held;
    do_reset();
    do_fetch(0, 0, 0, 0, addr, held);
    checks++; if (addr !== RST_PC) begin errs++; $display("FAIL first_addr got=%h want=%h", addr, RST_PC); end
    checks++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL first_inst_valid got=%b want=1", inst_valid); end
    checks++; if (inst !== 32'h00000013 || inst_pc !== RST_PC) begin errs++; $display("FAIL first_inst inst=%h pc=%h want=00000013,%h", inst, inst_pc, RST_PC); end
  endtask
  task automatic test_stalls();
    logic [31:0] addr; bit held; int f0;
    do_hold(5, 1, held);
    checks++; if (!held) begin errs++; $display("FAIL hold_stall inst=%h pc=%h cnt=%h not held", inst, inst_pc, retired_cnt); end
    checks++; if (retired_cnt !== 32'h0 || inst_pc !== RST_PC) begin errs++; $display("FAIL hold_commit_ignored cnt=%h pc=%h want=0,%h", retired_cnt, inst_pc, RST_PC); end
    do_commit(32'h80000010, 0);
    checks++; if (retired_cnt !== 32'h1 || req_addr !== 32'h80000010 || req_valid !== 1'b1) begin errs++; $display("FAIL commit cnt=%h addr=%h valid=%b want=1,80000010,1", retired_cnt, req_addr, req_valid); end
    f0 = req_fires;
    do_fetch(4, 2, 0, 0, addr, held);
    checks++; if (!held || addr !== 32'h80000010) begin errs++; $display("FAIL req_stall held=%b addr=%h want=1,80000010", held, addr); end
    checks++; if (req_fires - f0 !== 1) begin errs++; $display("FAIL single_request got=%0d want=1", req_fires - f0); end
    checks++; if (inst !== mem_word(32'h80000010)) begin errs++; $display("FAIL stall_inst got=%h want=%h", inst, mem_word(32'h80000010)); end
    do_hold(0, 0, held);
    do_commit(32'h80000040, 2);
  endtask
  task automatic test_random();
    logic [31:0] addr, npc; bit held; int f0;
    for (int n = 0; n < 40; n++) begin
      f0 = req_fires;
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 0, 1, addr, held);
      checks++; if (!held || addr !== exp_pc) begin errs++; $display("FAIL rnd_req[%0d] held=%b addr=%h want=%h", n, held, addr, exp_pc); end
      checks++; if (req_fires - f0 !== 1) begin errs++; $display("FAIL rnd_fires[%0d] got=%0d want=1", n, req_fires - f0); end
      checks++; if (inst_valid !== 1'b1 || inst !== mem_word(exp_pc) || inst_pc !== exp_pc) begin errs++; $display("FAIL rnd_inst[%0d] v=%b inst=%h pc=%h want=1,%h,%h", n, inst_valid, inst, inst_pc, mem_word(exp_pc), exp_pc); end
      do_hold($urandom_range(0, 3), 1'($urandom), held);
      checks++; if (!held) begin errs++; $display("FAIL rnd_hold[%0d] not held", n); end
      checks++; if (retired_cnt !== exp_cnt || fetch_err !== 1'b0) begin errs++; $display("FAIL rnd_cnt[%0d] cnt=%h err=%b want=%h,0", n, retired_cnt, fetch_err, exp_cnt); end
      npc = $urandom() & 32'hFFFFFFFC;
      do_commit(npc, $urandom_range(0, 3));
      checks++; if (retired_cnt !== exp_cnt || req_addr !== exp_pc) begin errs++; $display("FAIL rnd_commit[%0d] cnt=%h addr=%h want=%h,%h", n, retired_cnt, req_addr, exp_cnt, exp_pc); end
    end
  endtask
  task automatic test_misaligned();
    logic [31:0] addr, old_pc; bit held; int f0;
    do_fetch(0, 0, 0, 0, addr, held);
    do_hold(0, 0, held);
    old_pc = exp_pc;
    do_commit(32'h80000006, 1);
    checks++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL mis_err got=%b want=1", fetch_err); end
    checks++; if (req_valid !== 1'b0 || resp_ready !== 1'b0 || inst_valid !== 1'b0) begin errs++; $display("FAIL mis_outputs req=%b resp=%b inst=%b want=0,0,0", req_valid, resp_ready, inst_valid); end
    checks++; if (retired_cnt !== exp_cnt || inst_pc !== old_pc) begin errs++; $display("FAIL mis_state cnt=%h pc=%h want=%h,%h", retired_cnt, inst_pc, exp_cnt, old_pc); end
    f0 = req_fires;
    req_ready = 1; resp_valid = 1; inst_ready = 1; commit_valid = 1; next_pc = 32'h80000100;
    held = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      held &= req_valid === 1'b0 && inst_valid === 1'b0 && fetch_err === 1'b1;
    end
    clear_inputs();
    checks++; if (!held || req_fires != f0 || retired_cnt !== exp_cnt || inst_pc !== old_pc) begin errs++; $display("FAIL err_sticky held=%b cnt=%h pc=%h want=1,%h,%h", held, retired_cnt, inst_pc, exp_cnt, old_pc); end
  endtask
  task automatic test_resp_err();
    logic [31:0] addr; bit held;
    do_reset();
    do_fetch(0, 0, 0, 0, addr, held);
    do_hold(0, 0, held);
    do_commit(32'h80000020, 0);
    do_fetch(1, 1, 1, 0, addr, held);
    checks++; if (fetch_err !== 1'b1 || req_valid !== 1'b0) begin errs++; $display("FAIL resp_err err=%b req=%b want=1,0", fetch_err, req_valid); end
    held = 1;
    resp_valid = 1; resp_data = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      held &= inst_valid === 1'b0 && inst === 32'h00000013;
      step();
    end
    resp_valid = 0;
    checks++; if (!held || inst !== 32'h00000013) begin errs++; $display("FAIL resp_err_inst inst=%h valid=%b want=00000013,0", inst, inst_valid); end
  endtask
  task automatic test_reset_mid_resp();
    logic [31:0] addr; bit held;
    do_reset();
    do_fetch(0, 0, 0, 0, addr, held);
    do_hold(0, 0, held);
    do_commit(32'h80000010, 0);
    req_ready = 1;
    step();
    req_ready = 0;
    checks++; if (resp_ready !== 1'b1 || req_addr !== 32'h80000010 || retired_cnt !== 32'h1) begin errs++; $display("FAIL pre_reset resp=%b addr=%h cnt=%h want=1,80000010,1", resp_ready, req_addr, retired_cnt); end
    rst_n = 0; resp_valid = 1; resp_data = 32'hCAFEF00D;
    step();
    rst_n = 1; resp_valid = 0;
    checks++; if (req_addr !== RST_PC || req_valid !== 1'b1 || fetch_err !== 1'b0 || retired_cnt !== 32'h0) begin errs++; $display("FAIL mid_reset addr=%h req=%b err=%b cnt=%h want=%h,1,0,0", req_addr, req_valid, fetch_err, retired_cnt, RST_PC); end
    checks++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin errs++; $display("FAIL mid_reset_inst inst=%h valid=%b want=0,0", inst, inst_valid); end
    exp_pc = RST_PC; exp_cnt = 0;
    do_fetch(0, 0, 0, 0, addr, held);
    checks++; if (inst !== 32'h00000013 || inst_valid !== 1'b1) begin errs++; $display("FAIL restart inst=%h valid=%b want=00000013,1", inst, inst_valid); end
  endtask
  task automatic test_wrap();
    s_rst_n = 0; s_go = 1;
    step();
    s_rst_n = 1;
    for (int k = 1; k <= 17; k++) begin
      repeat (4) step();
      checks++; if (s_retired !== 4'(k)) begin errs++; $display("FAIL wrap_cnt[%0d] got=%h want=%h", k, s_retired, 4'(k)); end
    end
    checks++; if (s_fetch_err !== 1'b0 || s_addr !== 4'h4) begin errs++; $display("FAIL wrap_state err=%b addr=%h want=0,4", s_fetch_err, s_addr); end
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    s_rst_n = 0; s_go = 0;
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_stalls();
    test_random();
    test_misaligned();
    test_resp_err();
    test_reset_mid_resp();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
